switch_debouncer: RTL

- Input-conditioning stage directly upstream of the processor top's switches[9:0] port.
- Synchronises the 10 asynchronous board switches into the clk domain and debounces each bit independently.
- Drives clean levels into the memory-mapped switch read path.
- Also provides one-cycle rise/fall pulses and sticky per-bit event flags that software clears with write-1-to-clear.

---
 rtl/switch_debouncer.sv | 74 +++++++
 1 files changed

// File: rtl/switch_debouncer.sv
// Two-flop synchroniser plus independent per-bit debounce counters for the board switches,
// with registered rise/fall pulses and sticky write-1-to-clear event flags.
module switch_debouncer #(
  parameter int unsigned N_SW            = 10,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [N_SW-1:0] sw_raw,
  input  logic [N_SW-1:0] event_clr,
  output logic [N_SW-1:0] sw_clean,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall,
  output logic [N_SW-1:0] event_flags,
  output logic            any_change
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_SW-1:0]  sync1;
  logic [N_SW-1:0]  sync2;
  logic [N_SW-1:0]  stable;
  logic [N_SW-1:0]  accept;
  logic [CNT_W-1:0] cnt [N_SW];

  // A bit is accepted when the synchronised level has differed for DEBOUNCE_CYCLES edges.
  always_comb begin
    accept = '0;
    for (int unsigned i = 0; i < N_SW; i++) begin
      accept[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync1 <= '0;
      sync2 <= '0;
      for (int unsigned i = 0; i < N_SW; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
      for (int unsigned i = 0; i < N_SW; i++) begin
        if ((sync2[i] == stable[i]) || accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      stable      <= '0;
      sw_rise     <= '0;
      sw_fall     <= '0;
      any_change  <= 1'b0;
      event_flags <= '0;
    end else begin
      stable      <= stable ^ accept;
      sw_rise     <= accept & sync2;
      sw_fall     <= accept & ~sync2;
      any_change  <= |accept;
      // Flags capture the registered pulses, so a set always beats a same-cycle clear.
      event_flags <= (event_flags & ~event_clr) | sw_rise | sw_fall;
    end
  end

  assign sw_clean = stable;

endmodule
